// File: rtl/debounce_filter_pkg.sv
// debounce_pkg: shared types and constants for the debounce filter slice.
//   deb_state_t  - per-bit qualification FSM state
//   GLITCH_CNT_W - width of the optional glitch counter
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } deb_state_t;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/debounce_filter_if.sv
// debounce_filter_if: signal bundle between the debounce filter and its user.
//   din        - raw asynchronous inputs (WIDTH bits)
//   dout       - debounced levels (WIDTH bits)
//   busy       - per bit, candidate transition under qualification
//   glitch_clr - synchronous clear of glitch_cnt (DEBOUNCE_GLITCH_CNT_EN only)
//   glitch_cnt - saturating glitch cycle count (DEBOUNCE_GLITCH_CNT_EN only)
// modport master: the user side; modport slave: the filter side.
interface debounce_filter_if
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    glitch_clr;
  logic [GLITCH_CNT_W-1:0] glitch_cnt;
`endif

  modport master (
    output din,
    input  dout,
    input  busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output glitch_clr,
    input  glitch_cnt
`endif
  );

  modport slave (
    input  din,
    output dout,
    output busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    input  glitch_clr,
    output glitch_cnt
`endif
  );

endinterface

// File: rtl/debounce_filter_bit.sv
// debounce_bit: synchronizer chain, qualification FSM and stability counter
// for one input bit.
//   clk, n_rst - clock, asynchronous active-low reset
//   din        - raw asynchronous input
//   dout       - debounced level
//   busy       - high while a candidate transition is being qualified
//   glitch     - (DEBOUNCE_GLITCH_CNT_EN only) high in the cycle a pending
//                transition is abandoned back to the same stable level
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout,
  output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // dout is decoded from state rather than kept in its own flop: the level
  // only flips on PEND->STABLE entry, which is exactly the state encoding.
  assign dout = (state_q == STABLE_HI) || (state_q == PEND_LO);
  assign busy = (state_q == PEND_HI) || (state_q == PEND_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  assign glitch = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);
`endif

endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: per-bit input synchronizer and debounce filter.
//   clk   - sole clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - debounce_filter_if.slave (din in, dout/busy out)
// Optional feature macro DEBOUNCE_GLITCH_CNT_EN adds glitch_clr/glitch_cnt on
// the interface: an 8-bit saturating count of cycles in which any bit
// abandoned a pending transition; clear has priority over increment.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input logic              clk,
  input logic              n_rst,
  debounce_filter_if.slave bus
);

  logic [WIDTH-1:0] dout_w;
  logic [WIDTH-1:0] busy_w;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch_w;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (bus.din[i]),
      .dout  (dout_w[i]),
      .busy  (busy_w[i])
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch(glitch_w[i])
`endif
    );
  end

  assign bus.dout = dout_w;
  assign bus.busy = busy_w;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      glitch_cnt_q <= '0;
    end else if (bus.glitch_clr) begin
      glitch_cnt_q <= '0;
    end else if ((|glitch_w) && (glitch_cnt_q != '1)) begin
      glitch_cnt_q <= glitch_cnt_q + 1'b1;
    end
  end

  assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: directed bench for debounce_filter (WIDTH=4, default
// SYNC_STAGES=2, STABLE_CYCLES=8). Edge index i below means the i-th rising
// edge after din was changed; with these defaults dout follows after edge 9
// and busy is high after edges 2..8.
module tb_debounce_filter;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_pass;

  debounce_filter_if #(.WIDTH(4)) dif ();

  debounce_filter #(
    .WIDTH        (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_low();
    dif.din = 4'b0000;
    repeat (14) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_d, exp_b;
    n_rst   = 1'b0;
    dif.din = 4'b0001;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    dif.glitch_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dif.dout !== 4'b0000 || dif.busy !== 4'b0000)
        $display("FAIL reset_hold i=%0d: dout=%b busy=%b expected 0000/0000", i, dif.dout, dif.busy);
      else n_pass++;
    end
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_d = (i >= 9) ? 4'b0001 : 4'b0000;
      exp_b = (i >= 2 && i <= 8) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (dif.dout !== exp_d || dif.busy !== exp_b)
        $display("FAIL reset_release i=%0d: dout=%b busy=%b expected %b/%b", i, dif.dout, dif.busy, exp_d, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_step();
    logic [3:0] exp_d, exp_b;
    logic       prev;
    int         rises, falls;
    settle_low();
    n_checks++;
    if (dif.dout !== 4'b0000)
      $display("FAIL step_start: dout=%b expected 0000", dif.dout);
    else n_pass++;
    rises = 0;
    falls = 0;
    prev  = dif.dout[0];
    dif.din = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_d = (i >= 9) ? 4'b0001 : 4'b0000;
      exp_b = (i >= 2 && i <= 8) ? 4'b0001 : 4'b0000;
      if (dif.dout[0] && !prev) rises++;
      if (!dif.dout[0] && prev) falls++;
      prev = dif.dout[0];
      n_checks++;
      if (dif.dout !== exp_d || dif.busy !== exp_b)
        $display("FAIL step_rise i=%0d: dout=%b busy=%b expected %b/%b", i, dif.dout, dif.busy, exp_d, exp_b);
      else n_pass++;
    end
    dif.din = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_d = (i >= 9) ? 4'b0000 : 4'b0001;
      exp_b = (i >= 2 && i <= 8) ? 4'b0001 : 4'b0000;
      if (dif.dout[0] && !prev) rises++;
      if (!dif.dout[0] && prev) falls++;
      prev = dif.dout[0];
      n_checks++;
      if (dif.dout !== exp_d || dif.busy !== exp_b)
        $display("FAIL step_fall i=%0d: dout=%b busy=%b expected %b/%b", i, dif.dout, dif.busy, exp_d, exp_b);
      else n_pass++;
    end
    n_checks++;
    if (rises !== 1 || falls !== 1)
      $display("FAIL step_edges: rises=%0d falls=%0d expected 1/1", rises, falls);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [3:0] exp_b;
    for (int i = 0; i < 12; i++) begin
      dif.din = (i < 5) ? 4'b0001 : 4'b0000;
      step();
      exp_b = (i >= 2 && i <= 6) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (dif.dout !== 4'b0000 || dif.busy !== exp_b)
        $display("FAIL glitch5 i=%0d: dout=%b busy=%b expected 0000/%b", i, dif.dout, dif.busy, exp_b);
      else n_pass++;
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_checks++;
    if (dif.glitch_cnt !== 8'd1)
      $display("FAIL glitch5_cnt: glitch_cnt=%0d expected 1", dif.glitch_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_multi_bit();
    logic [3:0] exp_d, exp_b;
    for (int i = 0; i < 12; i++) begin
      dif.din = (i < 3) ? 4'b0111 : 4'b0101;
      step();
      exp_d = (i >= 9) ? 4'b0101 : 4'b0000;
      exp_b = ((i >= 2 && i <= 8) ? 4'b0101 : 4'b0000) |
              ((i >= 2 && i <= 4) ? 4'b0010 : 4'b0000);
      n_checks++;
      if (dif.dout !== exp_d || dif.busy !== exp_b)
        $display("FAIL multi_bit i=%0d: dout=%b busy=%b expected %b/%b", i, dif.dout, dif.busy, exp_d, exp_b);
      else n_pass++;
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_checks++;
    if (dif.glitch_cnt !== 8'd2)
      $display("FAIL multi_bit_cnt: glitch_cnt=%0d expected 2", dif.glitch_cnt);
    else n_pass++;
`endif
    settle_low();
    n_checks++;
    if (dif.dout !== 4'b0000)
      $display("FAIL multi_bit_settle: dout=%b expected 0000", dif.dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid_qual();
    logic [3:0] exp_d, exp_b;
    dif.din = 4'b0001;
    repeat (7) step();
    n_checks++;
    if (dif.busy !== 4'b0001)
      $display("FAIL midq_pending: busy=%b expected 0001", dif.busy);
    else n_pass++;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (dif.dout !== 4'b0000 || dif.busy !== 4'b0000)
      $display("FAIL midq_async: dout=%b busy=%b expected 0000/0000", dif.dout, dif.busy);
    else n_pass++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_checks++;
    if (dif.glitch_cnt !== 8'd0)
      $display("FAIL midq_cnt: glitch_cnt=%0d expected 0", dif.glitch_cnt);
    else n_pass++;
`endif
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_d = (i >= 9) ? 4'b0001 : 4'b0000;
      exp_b = (i >= 2 && i <= 8) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (dif.dout !== exp_d || dif.busy !== exp_b)
        $display("FAIL midq_restart i=%0d: dout=%b busy=%b expected %b/%b", i, dif.dout, dif.busy, exp_d, exp_b);
      else n_pass++;
    end
    settle_low();
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Single-cycle din pulse: the bit enters PEND_HI and drops back on the
  // fourth edge after din was raised.
  task automatic glitch_once();
    dif.din = 4'b0001;
    step();
    dif.din = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_glitch_cnt();
    for (int g = 0; g < 255; g++) glitch_once();
    n_checks++;
    if (dif.glitch_cnt !== 8'd255)
      $display("FAIL gcnt_255: glitch_cnt=%0d expected 255", dif.glitch_cnt);
    else n_pass++;
    for (int g = 0; g < 45; g++) glitch_once();
    n_checks++;
    if (dif.glitch_cnt !== 8'd255)
      $display("FAIL gcnt_sat: glitch_cnt=%0d expected 255", dif.glitch_cnt);
    else n_pass++;
    dif.din = 4'b0001;
    step();
    dif.din = 4'b0000;
    step();
    step();
    dif.glitch_clr = 1'b1;
    step();
    dif.glitch_clr = 1'b0;
    n_checks++;
    if (dif.glitch_cnt !== 8'd0)
      $display("FAIL gcnt_clr_wins: glitch_cnt=%0d expected 0", dif.glitch_cnt);
    else n_pass++;
    glitch_once();
    n_checks++;
    if (dif.glitch_cnt !== 8'd1)
      $display("FAIL gcnt_after_clr: glitch_cnt=%0d expected 1", dif.glitch_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_step();
    test_glitch();
    test_multi_bit();
    test_reset_mid_qual();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    test_glitch_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Per-bit input synchronizer and debounce filter that conditions raw asynchronous inputs (buttons, strap pins, external status lines) before they reach the edge detector. Each bit is passed through a synchronizer chain and must stay stable for a programmable number of cycles before the filtered output changes. Shorter glitches are discarded. The filtered output drives the edge detector's `signal` input directly, so one clean pos/neg pulse results per debounced transition.

## Interface
- `WIDTH`, default 1: number of independent bits.
- `SYNC_STAGES`, default 2: synchronizer flops per bit; legal range 2..4.
- `STABLE_CYCLES`, default 8: consecutive identical synchronized samples required to accept a new level; legal range ≥2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  raw, asynchronous inputs.
- `dout`  out  WIDTH  debounced level; connects to edge detector `signal`.
- `busy`  out  WIDTH  per bit: high while a candidate transition is being qualified.

## Operation
- Each bit runs an independent 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. Let `s` be the output of the last synchronizer flop.
- STABLE_LO: `s`=1 → PEND_HI, cnt←1; else hold.
- PEND_HI: `s`=0 → STABLE_LO, cnt←0 (glitch). `s`=1 and cnt=STABLE_CYCLES-1 → STABLE_HI, dout←1, cnt←0. Otherwise cnt←cnt+1.
- STABLE_HI and PEND_LO mirror the above with the polarity inverted; dout←0 on entry to STABLE_LO from PEND_LO.
- dout changes only on a PEND→STABLE transition. `busy` = state ∈ {PEND_HI, PEND_LO}, decoded combinationally from state.
- Counter width is $clog2(STABLE_CYCLES). It never exceeds STABLE_CYCLES-1, so no wrap can occur.
- Bits share no state. Simultaneous transitions on several bits are qualified independently.
- Reset: all synchronizer flops 0, every FSM in STABLE_LO, cnt 0, dout 0, busy 0. Asserting reset mid-qualification abandons the pending transition immediately.

## Timing
- For a `din` step captured at rising edge k and then held, `s` changes after edge k+SYNC_STAGES-1, and dout changes after edge k+SYNC_STAGES-1+STABLE_CYCLES.
- Defaults (2, 8): dout changes 9 cycles after the capturing edge.
- busy rises one cycle after `s` changes and falls in the same cycle dout updates.
- A pulse on `s` shorter than STABLE_CYCLES cycles never reaches dout. busy pulses for the pulse duration, then returns to 0.
- First release after reset: dout reflects a constant-high `din` no earlier than SYNC_STAGES-1+STABLE_CYCLES cycles after n_rst deasserts.

## Configuration
- `DEBOUNCE_GLITCH_CNT_EN` defined adds two ports:
  - `glitch_clr`  in  1: synchronous clear of the counter.
  - `glitch_cnt`  out  8: counts cycles in which at least one bit returned from PEND to the same STABLE state. The counter saturates at 255 and resets to 0. If `glitch_clr` and a glitch occur in the same cycle, the clear wins.
- Undefined: neither port exists and no counter logic is generated.

## Structure
- Shared package `debounce_pkg`:
  - `typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} deb_state_t`
  - `localparam GLITCH_CNT_W = 8`
- Sub-module `debounce_bit`: synchronizer, FSM and counter for a single bit, instantiated WIDTH times from a generate loop. The top level holds only the generate loop and the optional glitch counter.

## Test plan
- Reset with `din`=1: dout=0, busy=0 throughout. After release with SYNC_STAGES=2, STABLE_CYCLES=8: dout=1 exactly after edge 9, busy high during edges 2..8.
- 0→1 step held, then 1→0 step held: dout rises after 9 cycles and falls 9 cycles after the falling capture. Exactly one pos_edge and one neg_edge pulse appear when driving the edge detector.
- 5-cycle high glitch on `din` (STABLE_CYCLES=8): dout stays 0, busy pulses 5 cycles. With `DEBOUNCE_GLITCH_CNT_EN`, glitch_cnt=1.
- WIDTH=4, bits 0 and 2 stepped in the same cycle, bit 1 glitched 3 cycles: dout=4'b0101 after 9 cycles; bit 1 never changes.
- Reset asserted at cnt=5 in PEND_HI: dout, busy and cnt return to 0 asynchronously. After release, qualification restarts from cnt=0.
- With `DEBOUNCE_GLITCH_CNT_EN`: 300 glitches → glitch_cnt=255. glitch_clr asserted together with a glitch → glitch_cnt=0.
